// File: rtl/snn_pot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pot_pkg
//  Description : Shared types and constants for the membrane-potential
//                update engine (potential word type, FSM states, limits).
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pot_pkg;

    // One membrane potential / input current word
    typedef logic signed [31:0] pot_t;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Representable potential range, used when saturation is enabled
    localparam pot_t POT_MAX = 32'sh7FFF_FFFF;
    localparam pot_t POT_MIN = 32'sh8000_0000;

endpackage
`default_nettype wire

// File: rtl/pot_update_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : pot_update_engine_if
//  Description : Potential BRAM port bundle. The engine is the master (it
//                drives both read and write ports); the BRAM is the slave and
//                returns registered read data one cycle after pot_ren.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pot_update_engine_if #(
    parameter int ADDR_WIDTH = 5
);
    import snn_pot_pkg::*;

    logic                  pot_ren;
    logic [ADDR_WIDTH-1:0] pot_raddr;
    pot_t                  pot_rdat;
    logic                  pot_wren;
    logic [ADDR_WIDTH-1:0] pot_wraddr;
    pot_t                  pot_wrdat;

    modport master (
        output pot_ren,
        output pot_raddr,
        input  pot_rdat,
        output pot_wren,
        output pot_wraddr,
        output pot_wrdat
    );

    modport slave (
        input  pot_ren,
        input  pot_raddr,
        output pot_rdat,
        input  pot_wren,
        input  pot_wraddr,
        input  pot_wrdat
    );

endinterface
`default_nettype wire

// File: rtl/pot_neuron_alu.sv
`default_nettype none
// ============================================================================
//  Module      : pot_neuron_alu
//  Description : Combinational leak / integrate / fire for one neuron.
//                res = (pot - (pot >>> LEAK_SHIFT)) + cur, wrapped to 32 bits,
//                or clamped to the 32-bit signed range when POT_SAT_EN is
//                defined. fire = (res >= THRESHOLD).
//  Options     : `define POT_SAT_EN to saturate instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module pot_neuron_alu
    import snn_pot_pkg::*;
#(
    parameter int LEAK_SHIFT = 3,
    parameter int THRESHOLD  = 1024
) (
    input  pot_t pot,
    input  pot_t cur,
    output pot_t res,
    output logic fire
);

`ifdef POT_SAT_EN
    localparam logic signed [32:0] c_SUM_MAX = 33'(POT_MAX);
    localparam logic signed [32:0] c_SUM_MIN = 33'(POT_MIN);

    // Full-precision sum; 33 bits cannot overflow for two 32-bit operands
    logic signed [32:0] w_sum;
    assign w_sum = 33'(pot) - 33'(pot >>> LEAK_SHIFT) + 33'(cur);

    // Clamp into the representable potential range
    assign res = (w_sum > c_SUM_MAX) ? POT_MAX :
                 (w_sum < c_SUM_MIN) ? POT_MIN : pot_t'(w_sum[31:0]);
`else
    // Two's complement arithmetic in 32 bits gives the truncated sum directly
    assign res = pot - (pot >>> LEAK_SHIFT) + cur;
`endif

    assign fire = (res >= THRESHOLD);

endmodule
`default_nettype wire

// File: rtl/pot_update_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pot_update_engine
//  Description : Read-modify-write sweep engine for one SNN layer's 32-bit
//                potential BRAM. An update sweep consumes one current per
//                neuron (in index order), applies leak/integrate/fire and
//                writes the result back; a clear sweep zeroes every entry.
//                Pipeline: handshake T, BRAM data T+1, write/spike out T+2.
//  Options     : `define POT_SAT_EN for saturating (instead of wrapping) sums.
//  Revision    : 1.0 - initial release
// ============================================================================
module pot_update_engine
    import snn_pot_pkg::*;
#(
    parameter int NEURONS    = 32,
    parameter int ADDR_WIDTH = $clog2(NEURONS),
    parameter int LEAK_SHIFT = 3,
    parameter int THRESHOLD  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clr,
    output logic                    busy,
    output logic                    done,
    input  logic                    cur_valid,
    input  pot_t                    cur_data,
    output logic                    cur_ready,
    pot_update_engine_if.master     bram,
    output logic                    spk_valid,
    output logic [ADDR_WIDTH-1:0]   spk_addr,
    output logic [ADDR_WIDTH:0]     spk_count
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST    = ADDR_WIDTH'(NEURONS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_IDX_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE = (ADDR_WIDTH + 1)'(1);

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_s1_valid;
    pot_t                  r_s1_cur;
    logic [ADDR_WIDTH-1:0] r_s1_idx;
    logic                  r_wren;
    logic [ADDR_WIDTH-1:0] r_wraddr;
    pot_t                  r_wrdat;
    logic                  r_spk_valid;
    logic [ADDR_WIDTH-1:0] r_spk_addr;
    logic [ADDR_WIDTH:0]   r_spk_count;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_hs;
    pot_t                  w_res;
    logic                  w_fire;

    // RUN leaves as soon as the last index is issued, so in RUN there is
    // always another neuron to accept
    assign cur_ready       = (r_state == RUN);
    assign w_hs            = cur_valid && cur_ready;

    // Read is issued in the handshake cycle so rdat lines up with stage 1
    assign bram.pot_ren    = w_hs;
    assign bram.pot_raddr  = w_hs ? r_idx : '0;
    assign bram.pot_wren   = r_wren;
    assign bram.pot_wraddr = r_wraddr;
    assign bram.pot_wrdat  = r_wrdat;

    assign busy            = r_busy;
    assign done            = r_done;
    assign spk_valid       = r_spk_valid;
    assign spk_addr        = r_spk_addr;
    assign spk_count       = r_spk_count;

    pot_neuron_alu #(
        .LEAK_SHIFT (LEAK_SHIFT),
        .THRESHOLD  (THRESHOLD)
    ) u_alu (
        .pot  (bram.pot_rdat),
        .cur  (r_s1_cur),
        .res  (w_res),
        .fire (w_fire)
    );

    // Sweep controller plus the two pipeline stages with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_cur    <= '0;
            r_s1_idx    <= '0;
            r_wren      <= 1'b0;
            r_wraddr    <= '0;
            r_wrdat     <= '0;
            r_spk_valid <= 1'b0;
            r_spk_addr  <= '0;
            r_spk_count <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_wren      <= 1'b0;
            r_spk_valid <= 1'b0;

            // Stage 1: capture the current alongside the outstanding read
            r_s1_valid  <= w_hs;
            if (w_hs) begin
                r_s1_cur <= cur_data;
                r_s1_idx <= r_idx;
            end

            // Stage 2: write back the update; a firing neuron resets to 0
            if (r_s1_valid) begin
                r_wren      <= 1'b1;
                r_wraddr    <= r_s1_idx;
                r_wrdat     <= w_fire ? '0 : w_res;
                r_spk_valid <= w_fire;
                if (w_fire) begin
                    r_spk_addr  <= r_s1_idx;
                    r_spk_count <= r_spk_count + c_CNT_ONE;
                end
            end

            case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                    end else if (start) begin
                        r_state     <= RUN;
                        r_busy      <= 1'b1;
                        r_idx       <= '0;
                        r_spk_count <= '0;
                    end
                end
                CLEAR: begin
                    r_wren   <= 1'b1;
                    r_wraddr <= r_idx;
                    r_wrdat  <= '0;
                    r_idx    <= r_idx + c_IDX_ONE;
                    if (r_idx == c_LAST) begin
                        r_state <= DRAIN;
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        r_idx <= r_idx + c_IDX_ONE;
                        if (r_idx == c_LAST) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Stage 1 empty means the final write is on the port now
                    if (!r_s1_valid) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pot_update_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pot_update_engine
//  Description : Directed self-checking bench for pot_update_engine with a
//                behavioural registered-read BRAM and a negedge bus monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pot_update_engine;
    import snn_pot_pkg::*;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int LOGN = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          clr = 1'b0;
    logic          busy, done;
    logic          cur_valid = 1'b0;
    pot_t          cur_data = '0;
    logic          cur_ready;
    logic          spk_valid;
    logic [AW-1:0] spk_addr;
    logic [AW:0]   spk_count;

    pot_update_engine_if #(.ADDR_WIDTH(AW)) bram_if ();

    pot_update_engine #(
        .NEURONS(N), .ADDR_WIDTH(AW), .LEAK_SHIFT(3), .THRESHOLD(1024)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr), .busy(busy), .done(done),
        .cur_valid(cur_valid), .cur_data(cur_data), .cur_ready(cur_ready),
        .bram(bram_if), .spk_valid(spk_valid), .spk_addr(spk_addr), .spk_count(spk_count)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM with a backdoor preload port
    pot_t          mem [0:N-1];
    pot_t          rdat_q = '0;
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    pot_t          bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bram_if.pot_wren) mem[bram_if.pot_wraddr] <= bram_if.pot_wrdat;
        if (bram_if.pot_ren) rdat_q <= mem[bram_if.pot_raddr];
    end
    assign bram_if.pot_rdat = rdat_q;

    // Bus monitor: logs writes, spikes, handshakes, reads, done
    int   cyc = 0, wn = 0, sn = 0, hn = 0, rn = 0, bad_ren = 0;
    int   wlog_addr [0:LOGN-1];
    pot_t wlog_data [0:LOGN-1];
    int   wlog_cyc  [0:LOGN-1];
    int   slog_addr [0:LOGN-1];
    int   slog_cyc  [0:LOGN-1];
    int   hs_cyc    [0:LOGN-1];
    int   done_cyc = -1;
    logic done_busy = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bram_if.pot_wren && wn < LOGN) begin
            wlog_addr[wn] = int'(bram_if.pot_wraddr);
            wlog_data[wn] = bram_if.pot_wrdat;
            wlog_cyc[wn]  = cyc;
            wn = wn + 1;
        end
        if (spk_valid && sn < LOGN) begin
            slog_addr[sn] = int'(spk_addr);
            slog_cyc[sn]  = cyc;
            sn = sn + 1;
        end
        if (cur_valid && cur_ready && hn < LOGN) begin
            hs_cyc[hn] = cyc;
            hn = hn + 1;
        end
        if (bram_if.pot_ren) rn = rn + 1;
        if (bram_if.pot_ren !== (cur_valid && cur_ready)) bad_ren = bad_ren + 1;
        if (done) begin
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    int   n_checks = 0;
    int   n_fail = 0;
    pot_t cur_vec [0:N-1];
    pot_t exp_vec [0:N-1];

    // Number of logged writes from 'base' that deviate from address i / exp_vec[i]
    function automatic int sweep_errs(input int base);
        int e = 0;
        for (int i = 0; i < N; i++) begin
            if (wlog_addr[base+i] != i || wlog_data[base+i] !== exp_vec[i]) e++;
        end
        return e;
    endfunction

    task automatic pulse(input logic s, input logic c);
        @(posedge clk); #1;
        start = s; clr = c;
        @(posedge clk); #1;
        start = 1'b0; clr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done never seen, required 1", tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_sweep(input bit gaps, input string tag);
        int n = 0;
        int k = 0;
        bit hs;
        pulse(1'b1, 1'b0);
        while (n < N && k < 500) begin
            if (gaps && (k % 2 == 1)) begin
                cur_valid = 1'b0;
            end else begin
                cur_valid = 1'b1;
                cur_data  = cur_vec[n];
            end
            @(negedge clk);
            hs = cur_valid && cur_ready;
            @(posedge clk); #1;
            if (hs) n++;
            k++;
        end
        cur_valid = 1'b0;
        cur_data  = '0;
        n_checks++;
        if (n != N) begin
            n_fail++;
            $display("FAIL %s_handshakes: got %0d required %0d", tag, n, N);
        end
        wait_done(tag);
    endtask

    task automatic do_clear();
        pulse(1'b0, 1'b1);
        wait_done("clear");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, cur_ready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: busy/done/ready=%b required 000", {busy, done, cur_ready});
        end
        n_checks++;
        if ({bram_if.pot_ren, bram_if.pot_wren, bram_if.pot_raddr, bram_if.pot_wraddr} !== '0) begin
            n_fail++; $display("FAIL reset_bram: ren=%b wren=%b raddr=%0d wraddr=%0d required all 0",
                bram_if.pot_ren, bram_if.pot_wren, bram_if.pot_raddr, bram_if.pot_wraddr);
        end
        n_checks++;
        if (bram_if.pot_wrdat !== 32'sd0) begin
            n_fail++; $display("FAIL reset_wrdat: got %0d required 0", bram_if.pot_wrdat);
        end
        n_checks++;
        if ({spk_valid, spk_addr, spk_count} !== '0) begin
            n_fail++; $display("FAIL reset_spk: valid=%b addr=%0d count=%0d required 0", spk_valid, spk_addr, spk_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clear();
        int wb = wn, sb = sn, rb = rn, e = 0;
        // clr and start together: clear must win
        pulse(1'b1, 1'b1);
        wait_done("clr");
        n_checks++;
        if (wn - wb != N) begin
            n_fail++; $display("FAIL clr_write_count: got %0d required %0d", wn - wb, N);
        end
        for (int i = 0; i < N; i++) exp_vec[i] = '0;
        for (int i = 0; i < N; i++) if (wlog_cyc[wb+i] != wlog_cyc[wb] + i) e++;
        e += sweep_errs(wb);
        n_checks++;
        if (e != 0) begin
            n_fail++; $display("FAIL clr_write_seq: %0d bad writes, required 0", e);
        end
        n_checks++;
        if (sn - sb != 0 || rn - rb != 0) begin
            n_fail++; $display("FAIL clr_no_spk_read: spikes=%0d reads=%0d required 0/0", sn - sb, rn - rb);
        end
        n_checks++;
        if (done_cyc != wlog_cyc[wn-1] + 1 || done_busy !== 1'b0) begin
            n_fail++; $display("FAIL clr_done_timing: done_cyc=%0d busy=%b required %0d busy=0",
                done_cyc, done_busy, wlog_cyc[wn-1] + 1);
        end
    endtask

    task automatic test_update();
        int wb, hb;
        do_clear();
        for (int i = 0; i < N; i++) begin cur_vec[i] = 32'sd100; exp_vec[i] = 32'sd100; end
        wb = wn; hb = hn;
        do_sweep(1'b0, "upd1");
        n_checks++;
        if (wn - wb != N || sweep_errs(wb) != 0) begin
            n_fail++; $display("FAIL upd1_writes: count=%0d errs=%0d required %0d/0", wn - wb, sweep_errs(wb), N);
        end
        n_checks++;
        if (wlog_cyc[wb] != hs_cyc[hb] + 2 || wlog_cyc[wb+N-1] != wlog_cyc[wb] + N - 1) begin
            n_fail++; $display("FAIL upd1_latency: first_wr=%0d last_wr=%0d required %0d/%0d",
                wlog_cyc[wb], wlog_cyc[wb+N-1], hs_cyc[hb] + 2, hs_cyc[hb] + N + 1);
        end
        n_checks++;
        if (spk_count !== '0 || done_cyc != wlog_cyc[wn-1] + 1) begin
            n_fail++; $display("FAIL upd1_count_done: spk_count=%0d done_cyc=%0d required 0/%0d",
                spk_count, done_cyc, wlog_cyc[wn-1] + 1);
        end
        // 100 - (100>>>3) + 100 = 188
        for (int i = 0; i < N; i++) exp_vec[i] = 32'sd188;
        wb = wn;
        do_sweep(1'b0, "upd2");
        n_checks++;
        if (wn - wb != N || sweep_errs(wb) != 0 || spk_count !== '0) begin
            n_fail++; $display("FAIL upd2_writes: count=%0d errs=%0d spk_count=%0d required %0d/0/0",
                wn - wb, sweep_errs(wb), spk_count, N);
        end
    endtask

    task automatic test_single_spike();
        int wb, sb, hb;
        do_clear();
        for (int i = 0; i < N; i++) begin cur_vec[i] = '0; exp_vec[i] = '0; end
        cur_vec[5] = 32'sd2000;
        wb = wn; sb = sn; hb = hn;
        do_sweep(1'b0, "spk");
        n_checks++;
        if (sn - sb != 1 || slog_addr[sb] != 5) begin
            n_fail++; $display("FAIL spk_event: spikes=%0d addr=%0d required 1/5", sn - sb, slog_addr[sb]);
        end
        n_checks++;
        if (slog_cyc[sb] != hs_cyc[hb+5] + 2) begin
            n_fail++; $display("FAIL spk_timing: got cyc %0d required %0d", slog_cyc[sb], hs_cyc[hb+5] + 2);
        end
        n_checks++;
        if (sweep_errs(wb) != 0 || spk_count !== 6'd1) begin
            n_fail++; $display("FAIL spk_write_count: errs=%0d spk_count=%0d required 0/1", sweep_errs(wb), spk_count);
        end
    endtask

    task automatic test_bubbles();
        int rb, bb, e = 0;
        do_clear();
        for (int i = 0; i < N; i++) cur_vec[i] = 32'sd100;
        for (int s = 0; s < 2; s++) begin
            rb = rn; bb = bad_ren;
            do_sweep(1'b1, "bub");
            n_checks++;
            if (rn - rb != N || bad_ren != bb) begin
                n_fail++; $display("FAIL bub_ren: reads=%0d stray=%0d required %0d/0", rn - rb, bad_ren - bb, N);
            end
        end
        for (int i = 0; i < N; i++) if (mem[i] !== 32'sd188) e++;
        n_checks++;
        if (e != 0) begin
            n_fail++; $display("FAIL bub_contents: %0d entries differ, required all 188", e);
        end
    endtask

    task automatic test_overflow();
        int wb, sb;
        do_clear();
        @(posedge clk); #1;
        bd_we = 1'b1; bd_addr = 5'd3; bd_data = -32'sd1000000000;
        @(posedge clk); #1;
        bd_we = 1'b0;
        for (int i = 0; i < N; i++) begin cur_vec[i] = '0; exp_vec[i] = '0; end
        cur_vec[3] = -32'sd1500000000;
`ifdef POT_SAT_EN
        exp_vec[3] = 32'sh8000_0000;
`else
        exp_vec[3] = '0;
`endif
        wb = wn; sb = sn;
        do_sweep(1'b0, "ovf");
        n_checks++;
        if (sweep_errs(wb) != 0) begin
            n_fail++; $display("FAIL ovf_write: addr3 wrote %0d required %0d", wlog_data[wb+3], exp_vec[3]);
        end
`ifdef POT_SAT_EN
        n_checks++;
        if (sn - sb != 0 || spk_count !== 6'd0) begin
            n_fail++; $display("FAIL ovf_spike: spikes=%0d count=%0d required 0/0", sn - sb, spk_count);
        end
`else
        n_checks++;
        if (sn - sb != 1 || slog_addr[sb] != 3 || spk_count !== 6'd1) begin
            n_fail++; $display("FAIL ovf_spike: spikes=%0d addr=%0d count=%0d required 1/3/1",
                sn - sb, slog_addr[sb], spk_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int wb;
        do_clear();
        pulse(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cur_valid = 1'b1; cur_data = 32'sd100;
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, cur_ready, bram_if.pot_ren, bram_if.pot_wren, spk_valid} !== 6'b0
            || spk_count !== '0 || bram_if.pot_wraddr !== '0 || bram_if.pot_wrdat !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: busy=%b ready=%b ren=%b wren=%b cnt=%0d required all 0",
                busy, cur_ready, bram_if.pot_ren, bram_if.pot_wren, spk_count);
        end
        cur_valid = 1'b0; cur_data = '0;
        @(negedge clk);
        rst = 1'b0;
        do_clear();
        for (int i = 0; i < N; i++) begin cur_vec[i] = '0; exp_vec[i] = '0; end
        cur_vec[5]  = 32'sd2000;
        cur_vec[20] = 32'sd5000;
        wb = wn;
        do_sweep(1'b0, "midrst");
        n_checks++;
        if (spk_count !== 6'd2 || sweep_errs(wb) != 0 || done_busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_recover: spk_count=%0d errs=%0d busy_at_done=%b required 2/0/0",
                spk_count, sweep_errs(wb), done_busy);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_update();
        test_single_spike();
        test_bubbles();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
